uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART transmitter among 2**GID_W byte producers. It arbitrates pending requests, hands the winning byte to the transmitter using a start/busy handshake, and waits for the frame to finish. It then enforces a programmable inter-frame idle gap, counted in baud ticks from the clock divider, before serving the next request. It sits between the producer blocks and the UART TX datapath, in the clk_fast domain.

Parameters:
GID_W, 2, requester index width; N_REQ = 2**GID_W requesters (GID_W 1..3)
DATA_W, 8, byte width per requester
GAP_W, 4, width of gap_bits

Ports:
clk_fast  in  1  system clock; all logic on its rising edge
rst_n  in  1  synchronous, active-low reset
req  in  N_REQ  per-requester request level; held until own ack
req_data  in  N_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W]; stable while req[i]=1
ack  out  N_REQ  one-cycle pulse: byte of requester i accepted
baud_tick  in  1  one-cycle pulse per bit period, from divider
gap_bits  in  GAP_W  idle baud ticks inserted after each frame
tx_data  out  DATA_W  byte presented to transmitter
tx_start  out  1  one-cycle launch pulse to transmitter
tx_busy  in  1  transmitter frame in progress
grant_id  out  GID_W  index of the last granted requester
active  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n=0 at a clock edge) forces: state=IDLE, ack=0, tx_start=0, tx_data=0, grant_id=N_REQ-1, active=0, gap counter=0, rr pointer=N_REQ-1. This is the same from any state mid-frame: no ack or tx_start is issued for the aborted transfer.
- All outputs are registered.
- States and transitions:
  - IDLE: if |req, pick the first set req[i] scanning from (ptr+1) mod N_REQ upward with wrap. Capture tx_data<=req_data[i], grant_id<=i, ptr<=i. Go to LAUNCH. Otherwise stay.
  - LAUNCH (exactly 1 cycle): tx_start=1, ack[grant_id]=1, all other ack bits 0. Go to WAIT_BUSY.
  - WAIT_BUSY: stay until tx_busy=1, then go to TX.
  - TX: stay while tx_busy=1. On tx_busy=0: if gap_bits==0 go to IDLE; else load cnt<=gap_bits and go to GAP.
  - GAP: decrement cnt on each baud_tick. When baud_tick=1 and cnt==1, go to IDLE.
- Latency: req rising in IDLE at cycle 0 produces tx_start and ack in cycle 1. After tx_busy falls, IDLE is re-entered the next cycle with gap 0. With gap G, IDLE is entered the cycle after the G-th baud_tick that arrives in GAP.
- A baud_tick arriving in the same cycle as GAP entry is not counted.
- gap_bits is sampled only on TX->GAP. Changes during GAP have no effect.
- req changes outside IDLE are ignored. A req dropped before arbitration is never granted. A requester re-asserting immediately after its ack loses to any other pending requester (round-robin fairness).
- tx_data is held stable from LAUNCH until the next arbitration.
- A simultaneous baud_tick and tx_busy edge is irrelevant outside GAP.
- tx_busy already high on entry to WAIT_BUSY passes to TX the next cycle.
- At most one ack bit is ever high. ack and tx_start are always coincident.

Test Plan:
- Reset then req=4'b0001, data0=8'hA5, gap=0: cycle 1 has tx_start=1, ack=4'b0001, tx_data=A5, grant_id=0. Model busy for 10 cycles: IDLE and active=0 one cycle after busy falls.
- req=4'b1111 held, gap=0, bytes 11/22/33/44: grant order is 0,1,2,3,0. Each requester drops its req on ack and re-asserts 2 cycles later.
- gap_bits=3, baud_tick every 16 cycles, single request: next tx_start occurs no earlier than the cycle after the 3rd tick following busy fall. A second pending request is held off until then.
- req 2 and 3 pending with ptr=2: requester 3 wins. Next grant wraps to 2. Verify the pointer wrap-around.
- rst_n=0 asserted in TX and in GAP: all outputs return to reset values next edge. After release, with req=0 held for 5 cycles, no ack or tx_start appears.
- tx_busy delayed 4 cycles after tx_start: FSM holds in WAIT_BUSY, and tx_data stays stable. req change during TX produces no ack.

Source files
------------

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one UART transmitter
//
// Purpose:
//   Picks one of N_REQ = 2**GID_W byte producers in round-robin order and
//   hands its byte to the UART TX datapath with a start/busy handshake. It
//   then waits for the frame to end and holds off for gap_bits baud ticks
//   before the next request is arbitrated.
//
// Ports:
//   clk_fast   in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   req        in   [N_REQ]        per-requester request level
//   req_data   in   [N_REQ*DATA_W] requester i byte at [i*DATA_W +: DATA_W]
//   ack        out  [N_REQ]        one-cycle accept pulse for the granted requester
//   baud_tick  in   one pulse per bit period from the clock divider
//   gap_bits   in   [GAP_W]        idle baud ticks after each frame
//   tx_data    out  [DATA_W]       byte presented to the transmitter
//   tx_start   out  one-cycle launch pulse, coincident with ack
//   tx_busy    in   transmitter frame in progress
//   grant_id   out  [GID_W]        index of the last granted requester
//   active     out  high in every state except IDLE

module uart_tx_sched #(
    parameter int GID_W  = 2,
    parameter int DATA_W = 8,
    parameter int GAP_W  = 4
) (
    input  logic                          clk_fast,
    input  logic                          rst_n,
    input  logic [(1<<GID_W)-1:0]         req,
    input  logic [(1<<GID_W)*DATA_W-1:0]  req_data,
    output logic [(1<<GID_W)-1:0]         ack,
    input  logic                          baud_tick,
    input  logic [GAP_W-1:0]              gap_bits,
    output logic [DATA_W-1:0]             tx_data,
    output logic                          tx_start,
    input  logic                          tx_busy,
    output logic [GID_W-1:0]              grant_id,
    output logic                          active
);

    localparam int N_REQ = 1 << GID_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_TX,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [GID_W-1:0]    ptr_q, ptr_d;
    logic [GID_W-1:0]    grant_id_q, grant_id_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                tx_start_q, tx_start_d;
    logic                active_q, active_d;
    logic [GAP_W-1:0]    cnt_q, cnt_d;

    // Round-robin search result
    logic                found;
    logic [GID_W-1:0]    win;
    logic [GID_W-1:0]    idx;

    // Scan from ptr+1 upward with wrap; the last candidate (k = N_REQ)
    // truncates to ptr itself, so the previous winner has lowest priority.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ptr_q + GID_W'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        tx_data_d  = tx_data_q;
        cnt_d      = cnt_q;
        ack_d      = '0;
        tx_start_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    // ack/tx_start are registered here so they are high
                    // during the single LAUNCH cycle.
                    tx_data_d  = req_data[int'(win)*DATA_W +: DATA_W];
                    grant_id_d = win;
                    ptr_d      = win;
                    ack_d[win] = 1'b1;
                    tx_start_d = 1'b1;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_TX;
                end
            end
            S_TX: begin
                if (!tx_busy) begin
                    if (gap_bits == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        // Gap length is latched once; later gap_bits changes
                        // do not disturb a gap already in progress.
                        cnt_d   = gap_bits;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (baud_tick) begin
                    cnt_d = cnt_q - GAP_W'(1);
                    if (cnt_q == GAP_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        active_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_fast) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '1;
            grant_id_q <= '1;
            tx_data_q  <= '0;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            active_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            tx_data_q  <= tx_data_d;
            ack_q      <= ack_d;
            tx_start_q <= tx_start_d;
            active_q   <= active_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ack      = ack_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign grant_id = grant_id_q;
    assign active   = active_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard testbench for uart_tx_sched
module tb_uart_tx_sched;

    localparam int GID_W  = 2;
    localparam int DATA_W = 8;
    localparam int GAP_W  = 4;
    localparam int N_REQ  = 4;

    logic                      clk_fast;
    logic                      rst_n;
    logic [N_REQ-1:0]          req;
    logic [N_REQ*DATA_W-1:0]   req_data;
    logic [N_REQ-1:0]          ack;
    logic                      baud_tick;
    logic [GAP_W-1:0]          gap_bits;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_start;
    logic                      tx_busy;
    logic [GID_W-1:0]          grant_id;
    logic                      active;

    uart_tx_sched #(.GID_W(GID_W), .DATA_W(DATA_W), .GAP_W(GAP_W)) dut (
        .clk_fast  (clk_fast),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .baud_tick (baud_tick),
        .gap_bits  (gap_bits),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .active    (active)
    );

    typedef struct {
        int               id;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   start_cycs[$];
    int   tick_cycs[$];
    int   checks;
    int   failures;
    int   cyc;
    int   n_starts;
    int   fall_cyc;
    int   busy_delay;
    int   busy_len;
    bit   tick_en;
    bit   rearm_en;
    int   rearm_cnt[N_REQ];

    initial begin
        clk_fast = 1'b0;
        forever #5 clk_fast = ~clk_fast;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk_fast);
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int id, input logic [DATA_W-1:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every launch pops one expected grant.
    initial begin
        exp_t e;
        n_starts = 0;
        forever begin
            @(negedge clk_fast);
            if (tx_start || (ack != '0)) begin
                n_starts++;
                start_cycs.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start: grant_id=%0d ack=%b, no grant expected (cycle %0d)", grant_id, ack, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("start_pulse", 32'(tx_start), 32'd1);
                    chk("ack_onehot", 32'(ack), 32'd1 << e.id);
                    chk("grant_id", 32'(grant_id), 32'(e.id));
                    chk("tx_data", 32'(tx_data), 32'(e.data));
                end
            end
        end
    end

    // Transmitter model: busy rises busy_delay cycles after the launch
    // cycle and stays up for busy_len cycles.
    initial begin
        tx_busy  = 1'b0;
        fall_cyc = -1;
        forever begin
            @(negedge clk_fast);
            if (tx_start) begin
                repeat (busy_delay) begin
                    @(posedge clk_fast);
                    #1;
                end
                tx_busy = 1'b1;
                repeat (busy_len) begin
                    @(posedge clk_fast);
                    #1;
                end
                tx_busy  = 1'b0;
                fall_cyc = cyc;
            end
        end
    end

    // Baud divider model: one tick every 16 cycles when enabled.
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(posedge clk_fast);
            #1;
            baud_tick = tick_en && ((cyc % 16) == 0);
            if (baud_tick) tick_cycs.push_back(cyc);
        end
    end

    // Advance one cycle; requesters drop req after their ack and, when
    // rearm_en is set, raise it again two cycles later.
    task automatic step();
        logic [N_REQ-1:0] a;
        a = ack;
        @(posedge clk_fast);
        #2;
        for (int i = 0; i < N_REQ; i++) begin
            if (a[i]) begin
                req[i]       = 1'b0;
                rearm_cnt[i] = rearm_en ? 2 : 0;
            end else if (rearm_cnt[i] > 0) begin
                rearm_cnt[i]--;
                if (rearm_cnt[i] == 0 && rearm_en) req[i] = 1'b1;
            end
        end
    endtask

    task automatic wait_starts(input int target, input int bound, input string name);
        int n;
        n = 0;
        while (n_starts < target && n < bound) begin
            step();
            n++;
        end
        checks++;
        if (n_starts < target) begin
            failures++;
            $display("FAIL %s: starts=%0d expected %0d within %0d cycles", name, n_starts, target, bound);
        end
    endtask

    task automatic wait_fall(input int bound, input string name);
        int n;
        n = 0;
        while (fall_cyc != cyc && n < bound) begin
            step();
            n++;
        end
        checks++;
        if (fall_cyc != cyc) begin
            failures++;
            $display("FAIL %s: tx_busy fall not seen within %0d cycles", name, bound);
        end
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n;
        n = 0;
        while ((active || tx_busy) && n < bound) begin
            step();
            n++;
        end
        checks++;
        if (active || tx_busy) begin
            failures++;
            $display("FAIL %s: active=%0b tx_busy=%0b after %0d cycles, expected idle", name, active, tx_busy, bound);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_grant_id"}, 32'(grant_id), 32'd3);
        chk({tag, "_active"}, 32'(active), 32'd0);
    endtask

    task automatic quiet(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            chk({tag, "_ack"}, 32'(ack), 32'd0);
            chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        end
    endtask

    initial begin
        int base;
        int f;
        int t3;
        int nt;
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        req        = '0;
        req_data   = '0;
        gap_bits   = '0;
        tick_en    = 1'b0;
        rearm_en   = 1'b0;
        busy_delay = 1;
        busy_len   = 10;
        for (int i = 0; i < N_REQ; i++) rearm_cnt[i] = 0;

        // Reset state
        repeat (3) step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Single request, gap 0: launch one cycle after req
        req_data[7:0] = 8'hA5;
        req = 4'b0001;
        push_exp(0, 8'hA5);
        step();
        chk("lat_tx_start", 32'(tx_start), 32'd1);
        chk("lat_ack", 32'(ack), 32'b0001);
        chk("lat_grant_id", 32'(grant_id), 32'd0);
        chk("lat_tx_data", 32'(tx_data), 32'hA5);
        wait_fall(40, "t1_fall");
        chk("t1_active_in_tx", 32'(active), 32'd1);
        step();
        chk("t1_idle_after_fall", 32'(active), 32'd0);
        chk("t1_data_hold", 32'(tx_data), 32'hA5);

        // All four requesting with re-arm: order 0,1,2,3,0 from reset pointer
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        rearm_en = 1'b1;
        push_exp(0, 8'h11);
        push_exp(1, 8'h22);
        push_exp(2, 8'h33);
        push_exp(3, 8'h44);
        push_exp(0, 8'h11);
        base = n_starts;
        req  = 4'b1111;
        wait_starts(base + 5, 200, "t2_rr_starts");
        rearm_en = 1'b0;
        req      = '0;
        for (int i = 0; i < N_REQ; i++) rearm_cnt[i] = 0;
        wait_idle(60, "t2_idle");

        // Gap of 3 ticks; second request held off until after the third tick
        gap_bits = 4'd3;
        tick_en  = 1'b1;
        req_data[7:0] = 8'h5A;
        push_exp(0, 8'h5A);
        base = n_starts;
        req[0] = 1'b1;
        wait_starts(base + 1, 20, "t3_first_start");
        req_data[15:8] = 8'h6B;
        req[1] = 1'b1;
        push_exp(1, 8'h6B);
        wait_fall(40, "t3_fall");
        f = fall_cyc;
        step();
        step();
        gap_bits = 4'd1;
        wait_starts(base + 2, 120, "t3_second_start");
        t3 = -1;
        nt = 0;
        foreach (tick_cycs[i]) begin
            if (tick_cycs[i] > f) begin
                nt++;
                if (nt == 3 && t3 < 0) t3 = tick_cycs[i];
            end
        end
        chk("t3_gap_start_cycle", 32'(start_cycs[start_cycs.size()-1]), 32'(t3 + 2));
        wait_idle(200, "t3_idle");
        tick_en  = 1'b0;
        gap_bits = '0;

        // Pointer wrap: make ptr=2, then 2 and 3 pending -> 3 then 2
        req_data[23:16] = 8'hC2;
        push_exp(2, 8'hC2);
        base = n_starts;
        req[2] = 1'b1;
        wait_starts(base + 1, 20, "t4_first");
        wait_idle(40, "t4_idle_a");
        req_data[23:16] = 8'hE2;
        req_data[31:24] = 8'hD3;
        push_exp(3, 8'hD3);
        push_exp(2, 8'hE2);
        req = 4'b1100;
        wait_starts(base + 3, 80, "t4_wrap");
        wait_idle(40, "t4_idle_b");
        chk("t4_last_grant", 32'(grant_id), 32'd2);

        // Reset during TX
        req_data[7:0] = 8'h77;
        push_exp(0, 8'h77);
        base = n_starts;
        req[0] = 1'b1;
        wait_starts(base + 1, 20, "t5_start");
        step();
        step();
        chk("t5_in_tx", 32'({active, tx_busy}), 32'b11);
        rst_n = 1'b0;
        step();
        chk_reset_outputs("rst_tx");
        rst_n = 1'b1;
        quiet(5, "rst_tx_quiet");
        wait_fall(40, "t5_busy_end");
        step();

        // Reset during GAP
        gap_bits = 4'd2;
        tick_en  = 1'b1;
        req_data[7:0] = 8'h88;
        push_exp(0, 8'h88);
        base = n_starts;
        req[0] = 1'b1;
        wait_starts(base + 1, 20, "t5g_start");
        wait_fall(40, "t5g_fall");
        step();
        step();
        chk("t5g_in_gap", 32'(active), 32'd1);
        rst_n = 1'b0;
        step();
        chk_reset_outputs("rst_gap");
        rst_n    = 1'b1;
        tick_en  = 1'b0;
        gap_bits = '0;
        quiet(5, "rst_gap_quiet");

        // Late busy: hold in WAIT_BUSY with stable data; req change in TX ignored
        busy_delay = 4;
        req_data[15:8] = 8'h99;
        push_exp(1, 8'h99);
        base = n_starts;
        req[1] = 1'b1;
        wait_starts(base + 1, 20, "t6_start");
        for (int i = 0; i < 5; i++) begin
            chk("t6_wait_active", 32'(active), 32'd1);
            chk("t6_wait_data", 32'(tx_data), 32'h99);
            step();
        end
        req_data[23:16] = 8'hF0;
        req[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_tx_no_ack", 32'(ack), 32'd0);
        end
        req[2] = 1'b0;
        wait_idle(40, "t6_idle");
        quiet(5, "t6_quiet");
        chk("t6_data_hold", 32'(tx_data), 32'h99);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
